// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder emulator: default clock and
// resolution, the step-constant derivation and the quadrature state type.
package enc_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned CPR_DEF    = 250;

  // Largest value rpm_in can carry; the step constant must exceed it so
  // that at most one quadrature step is produced per clock.
  localparam int unsigned RPM_MAX = 32767;

  // State encoding is {A,B}, so the outputs are the state bits themselves.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_state_e;

  // Accumulator threshold: clock cycles per minute divided by edges per rev.
  function automatic longint unsigned enc_k(input longint unsigned clk_hz,
                                            input longint unsigned cpr);
    return (clk_hz * 64'd60) / (64'd4 * cpr);
  endfunction

  // True when the threshold divides exactly (fractional K is not supported).
  function automatic bit enc_k_exact(input longint unsigned clk_hz,
                                     input longint unsigned cpr);
    return ((clk_hz * 64'd60) % (64'd4 * cpr)) == 64'd0;
  endfunction

endpackage

// File: rtl/quad_fsm.sv
// Quadrature sequencer: advances one state per step in the commanded
// direction, registers A/B, flags A rising edges, and reports the signed
// position change caused by the current step. The current state is an
// output so checkers can observe the FSM directly.
module quad_fsm
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              dir,
  output logic              a,
  output logic              b,
  output logic              tick,
  output logic signed [1:0] delta,
  output quad_state_e       state
);

  quad_state_e state_nxt;
  logic        tick_nxt;

  // State register and registered A-rise flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= Q00;
      tick  <= 1'b0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
    end
  end

  // Next state, A-rise detection and position delta for this cycle's step.
  always_comb begin
    state_nxt = state;
    delta     = 2'sd0;
    if (step) begin
      delta = dir ? 2'sd1 : -2'sd1;
      case (state)
        Q00:     state_nxt = dir ? Q10 : Q01;
        Q10:     state_nxt = dir ? Q11 : Q00;
        Q11:     state_nxt = dir ? Q01 : Q10;
        Q01:     state_nxt = dir ? Q00 : Q11;
        default: state_nxt = Q00;
      endcase
    end
    tick_nxt = state_nxt[1] & ~state[1];
  end

  assign a = state[1];
  assign b = state[0];

endmodule

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator. A phase accumulator adds the commanded RPM
// every clock and emits one quadrature step each time it crosses
// K = CLK_HZ*60/(4*CPR); quad_fsm turns steps into A/B, tick and position.
//
// load is a one-cycle strobe with no ready: the block accepts it in any
// cycle and the captured values take effect from the following cycle.
//
// Optional feature: define ENC_INDEX_EN to add the enc_z index output,
// driven from a per-revolution A-cycle counter.
module encoder_emulator
  import enc_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF,
  parameter int unsigned CPR    = CPR_DEF,
  parameter int unsigned ACC_W  = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [14:0]        rpm_in,
  input  logic               dir_in,
  input  logic               load,
  output logic               enc_a,
  output logic               enc_b,
  output logic               tick,
  output logic signed [15:0] position,
  output logic               running
`ifdef ENC_INDEX_EN
  ,
  output logic               enc_z
`endif
);

  localparam longint unsigned K_L = enc_k(64'(CLK_HZ), 64'(CPR));
  localparam int unsigned     SW  = ACC_W + 1;
  localparam logic [SW-1:0]   K   = SW'(K_L);

  if (!enc_k_exact(64'(CLK_HZ), 64'(CPR))) begin : g_k_not_integer
    $error("encoder_emulator: CLK_HZ*60/(4*CPR) is not an integer");
  end
  if (K_L <= 64'(RPM_MAX)) begin : g_k_too_small
    $error("encoder_emulator: K must exceed 32767 to keep one step per cycle");
  end
  if (K_L >= (64'd1 << ACC_W)) begin : g_acc_too_narrow
    $error("encoder_emulator: ACC_W too narrow to hold K");
  end

  logic [ACC_W-1:0]   acc;
  logic [14:0]        rpm_q;
  logic               dir_q;
  logic [SW-1:0]      sum;
  logic               step;
  logic signed [1:0]  delta;
  quad_state_e        q_state;

  // Capture the speed/direction command on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpm_q <= '0;
      dir_q <= 1'b1;
    end else if (load) begin
      rpm_q <= rpm_in;
      dir_q <= dir_in;
    end
  end

  // Accumulator overflow test; uses the command already held this cycle.
  always_comb begin
    sum  = SW'(acc) + SW'(rpm_q);
    step = (rpm_q != '0) && (sum >= K);
  end

  // Phase accumulator: wraps by K on each step, frozen while speed is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (rpm_q != '0) begin
      acc <= step ? ACC_W'(sum - K) : ACC_W'(sum);
    end
  end

  quad_fsm u_quad_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .dir   (dir_q),
    .a     (enc_a),
    .b     (enc_b),
    .tick  (tick),
    .delta (delta),
    .state (q_state)
  );

  // Signed edge counter, wrapping modulo 2^16, updated with the A/B change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= '0;
    end else begin
      position <= position + {{14{delta[1]}}, delta};
    end
  end

  assign running = (rpm_q != '0);

  // The quadrature state may only move in a cycle that carried a step.
  a_state_moves_on_step : assert property (
    @(posedge clk) disable iff (!rst_n) !step |=> $stable(q_state)
  );

`ifdef ENC_INDEX_EN
  localparam int unsigned RW = (CPR > 1) ? $clog2(CPR) : 1;

  logic [RW-1:0] rev_cnt;
  logic [RW-1:0] rev_nxt;
  logic          at_q00_nxt;

  // A-cycle counter: forward counts on Q01->Q00, reverse on Q00->Q01.
  always_comb begin
    rev_nxt    = rev_cnt;
    at_q00_nxt = (q_state == Q00);
    if (step) begin
      if (dir_q) begin
        at_q00_nxt = (q_state == Q01);
        if (q_state == Q01) begin
          rev_nxt = (rev_cnt == RW'(CPR - 1)) ? '0 : rev_cnt + RW'(1);
        end
      end else begin
        at_q00_nxt = (q_state == Q10);
        if (q_state == Q00) begin
          rev_nxt = (rev_cnt == '0) ? RW'(CPR - 1) : rev_cnt - RW'(1);
        end
      end
    end
  end

  // Index pulse registered alongside A/B: high in Q00 of A-cycle zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_cnt <= '0;
      enc_z   <= 1'b0;
    end else begin
      rev_cnt <= rev_nxt;
      enc_z   <= at_q00_nxt && (rev_nxt == '0);
    end
  end
`endif

endmodule
